// File: rtl/multi_lane_crossroad_ctrl.sv
// Timed crossroad controller: per-lane saturating car counters, ALL_RED/GREEN/YELLOW phase FSM
// and round-robin selection of the next non-empty lane.
module multi_lane_crossroad_ctrl #(
   parameter int  NUM_LANES    = 4,
   parameter int  CNT_W        = 4,
   parameter int  TICK_DIV     = 50000000,
   parameter int  GREEN_MIN    = 3,
   parameter int  GREEN_MAX    = 10,
   parameter int  YELLOW_TICKS = 2,
   parameter int  ALLRED_TICKS = 1,
   localparam int LANE_W       = $clog2(NUM_LANES)
) (
   input  logic                       CLK100MHZ,
   input  logic                       CPU_RESETN,
   input  logic [NUM_LANES-1:0]       car_arrive,
   input  logic                       car_cross,
   input  logic                       manual_advance,
   output logic [2*NUM_LANES-1:0]     light,
   output logic [CNT_W*NUM_LANES-1:0] car_count,
   output logic [LANE_W-1:0]          active_lane,
   output logic [1:0]                 phase,
   output logic [NUM_LANES-1:0]       sat
);

   localparam int TMR_W = $clog2(GREEN_MAX + 1);
   localparam int PRE_W = $clog2(TICK_DIV);

   localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
   localparam logic [TMR_W-1:0] T_GMIN    = TMR_W'(GREEN_MIN);
   localparam logic [TMR_W-1:0] T_GMAX    = TMR_W'(GREEN_MAX);
   localparam logic [TMR_W-1:0] T_YELLOW  = TMR_W'(YELLOW_TICKS);
   localparam logic [TMR_W-1:0] T_ALLRED  = TMR_W'(ALLRED_TICKS);
   localparam logic [1:0]       LT_GREEN  = 2'b01;
   localparam logic [1:0]       LT_YELLOW = 2'b10;

   typedef enum logic [1:0] {
      ALL_RED = 2'd0,
      GREEN   = 2'd1,
      YELLOW  = 2'd2
   } phase_e;

   phase_e               state;
   logic [PRE_W-1:0]     presc;
   logic [TMR_W-1:0]     timer;
   logic [TMR_W-1:0]     timer_inc;
   logic                 tick;
   logic [LANE_W-1:0]    rr_ptr;
   logic [LANE_W-1:0]    pick;
   logic                 found;
   logic [CNT_W-1:0]     cnt [NUM_LANES];
   logic [NUM_LANES-1:0] cross_hit;
   logic [NUM_LANES-1:0] full;
   logic                 red_go;
   logic                 green_end;
   logic                 yellow_end;

   function automatic logic [LANE_W-1:0] lane_after(input logic [LANE_W-1:0] base, input int step);
      return LANE_W'((int'(base) + step) % NUM_LANES);
   endfunction

   function automatic logic [2*NUM_LANES-1:0] lane_light(input logic [LANE_W-1:0] lane,
                                                         input logic [1:0]        code);
      logic [2*NUM_LANES-1:0] l;
      l = '0;
      l[2*int'(lane) +: 2] = code;
      return l;
   endfunction

   assign tick      = (presc == PRE_LAST);
   assign timer_inc = (tick && timer != T_GMAX) ? timer + 1'b1 : timer;

   // NOTE: found/pick get their defaults before the loop, so no path leaves them unassigned (no latch).
   always_comb begin
      found = 1'b0;
      pick  = rr_ptr;
      for (int k = 1; k <= NUM_LANES; k++) begin
         if (!found && cnt[lane_after(rr_ptr, k)] != '0) begin
            found = 1'b1;
            pick  = lane_after(rr_ptr, k);
         end
      end
   end

   always_comb begin
      full      = '0;
      cross_hit = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         full[i]      = (cnt[i] == '1);
         cross_hit[i] = car_cross && (state == GREEN) && (active_lane == LANE_W'(i)) && (cnt[i] != '0);
      end
   end

   assign red_go     = (timer >= T_ALLRED) && found;
   assign green_end  = (timer == T_GMAX) ||
                       ((timer >= T_GMIN) && ((cnt[active_lane] == '0) || manual_advance));
   assign yellow_end = (timer == T_YELLOW);

   // Every phase entry restarts the prescaler and tick timer, so each phase is timed from entry.
   // NOTE: all state is updated with <=, so every decision below sees the pre-edge values.
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         state       <= ALL_RED;
         presc       <= '0;
         timer       <= '0;
         rr_ptr      <= LANE_W'(NUM_LANES - 1);
         active_lane <= '0;
         light       <= '0;
      end else begin
         presc <= tick ? '0 : presc + 1'b1;
         timer <= timer_inc;
         case (state)
            ALL_RED: if (red_go) begin
               state       <= GREEN;
               active_lane <= pick;
               rr_ptr      <= pick;
               light       <= lane_light(pick, LT_GREEN);
               presc       <= '0;
               timer       <= '0;
            end
            GREEN: if (green_end) begin
               state <= YELLOW;
               light <= lane_light(active_lane, LT_YELLOW);
               presc <= '0;
               timer <= '0;
            end
            YELLOW: if (yellow_end) begin
               state <= ALL_RED;
               light <= '0;
               presc <= '0;
               timer <= '0;
            end
            default: begin
               state <= ALL_RED;
               light <= '0;
               presc <= '0;
               timer <= '0;
            end
         endcase
      end
   end

   // Simultaneous arrive and effective cross on one lane cancel out, including at saturation.
   // NOTE: the counter array is architectural state, not RAM, so every entry is reset.
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         for (int i = 0; i < NUM_LANES; i++) cnt[i] <= '0;
         sat <= '0;
      end else begin
         for (int i = 0; i < NUM_LANES; i++) begin
            sat[i] <= car_arrive[i] && full[i] && !cross_hit[i];
            if (car_arrive[i] && !cross_hit[i] && !full[i])
               cnt[i] <= cnt[i] + 1'b1;
            else if (cross_hit[i] && !car_arrive[i])
               cnt[i] <= cnt[i] - 1'b1;
         end
      end
   end

   assign phase = state;

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_count
      assign car_count[g*CNT_W +: CNT_W] = cnt[g];
   end

endmodule

// File: tb/tb_multi_lane_crossroad_ctrl.sv
// Scoreboard bench: a per-cycle reference model pushes expected outputs, a monitor compares them.
module tb_multi_lane_crossroad_ctrl;

   localparam int NL   = 4;
   localparam int CW   = 3;
   localparam int TD   = 4;
   localparam int GMIN = 2;
   localparam int GMAX = 5;
   localparam int YT   = 2;
   localparam int ART  = 1;
   localparam int MAXC = (1 << CW) - 1;

   typedef struct {
      int phase;
      int lane;
      int light;
      int counts;
      int sat;
   } exp_t;

   logic             clk            = 1'b0;
   logic             rst_n          = 1'b1;
   logic [NL-1:0]    car_arrive     = '0;
   logic             car_cross      = 1'b0;
   logic             manual_advance = 1'b0;
   logic [2*NL-1:0]  light;
   logic [CW*NL-1:0] car_count;
   logic [1:0]       active_lane;
   logic [1:0]       phase;
   logic [NL-1:0]    sat;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Reference model: elapsed counts clock edges since the current phase began.
   int m_cnt[NL];
   int m_phase   = 0;
   int m_lane    = 0;
   int m_ptr     = NL - 1;
   int m_elapsed = 0;
   int m_sat     = 0;

   multi_lane_crossroad_ctrl #(
      .NUM_LANES(NL), .CNT_W(CW), .TICK_DIV(TD), .GREEN_MIN(GMIN),
      .GREEN_MAX(GMAX), .YELLOW_TICKS(YT), .ALLRED_TICKS(ART)
   ) dut (
      .CLK100MHZ(clk),
      .CPU_RESETN(rst_n),
      .car_arrive(car_arrive),
      .car_cross(car_cross),
      .manual_advance(manual_advance),
      .light(light),
      .car_count(car_count),
      .active_lane(active_lane),
      .phase(phase),
      .sat(sat)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish by %0t", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input int act, input int want);
      n_checks++;
      if (act == want) n_pass++;
      else $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, want);
   endtask

   task automatic timeout(input string tag);
      n_checks++;
      $display("FAIL %s: wait bound expired at %0t", tag, $time);
   endtask

   function automatic void model_step(input logic [NL-1:0] arr, input bit cr, input bit adv,
                                      input bit in_reset);
      int ticks, nphase, nlane, nsat, want;
      int ncnt[NL];
      bit moved;
      if (in_reset) begin
         for (int i = 0; i < NL; i++) m_cnt[i] = 0;
         m_phase = 0; m_lane = 0; m_ptr = NL - 1; m_elapsed = 0; m_sat = 0;
      end else begin
         ticks  = m_elapsed / TD;
         nphase = m_phase;
         nlane  = m_lane;
         moved  = 1'b0;
         if (m_phase == 0 && ticks >= ART) begin
            for (int k = 1; k <= NL; k++) begin
               if (!moved && m_cnt[(m_ptr + k) % NL] > 0) begin
                  nlane  = (m_ptr + k) % NL;
                  nphase = 1;
                  moved  = 1'b1;
               end
            end
         end else if (m_phase == 1 &&
                      (ticks == GMAX || (ticks >= GMIN && (m_cnt[m_lane] == 0 || adv)))) begin
            nphase = 2;
            moved  = 1'b1;
         end else if (m_phase == 2 && ticks == YT) begin
            nphase = 0;
            moved  = 1'b1;
         end
         nsat = 0;
         for (int i = 0; i < NL; i++) begin
            want = m_cnt[i] + int'(arr[i]) -
                   ((cr && m_phase == 1 && m_lane == i && m_cnt[i] > 0) ? 1 : 0);
            if (want > MAXC) begin
               nsat |= (1 << i);
               want = MAXC;
            end
            ncnt[i] = want;
         end
         for (int i = 0; i < NL; i++) m_cnt[i] = ncnt[i];
         if (m_phase == 0 && nphase == 1) m_ptr = nlane;
         m_phase   = nphase;
         m_lane    = nlane;
         m_sat     = nsat;
         m_elapsed = moved ? 0 : m_elapsed + 1;
      end
   endfunction

   function automatic exp_t snapshot();
      exp_t e;
      e.phase  = m_phase;
      e.lane   = m_lane;
      e.light  = (m_phase == 1) ? (1 << (2 * m_lane)) :
                 (m_phase == 2) ? (2 << (2 * m_lane)) : 0;
      e.counts = 0;
      for (int i = 0; i < NL; i++) e.counts |= m_cnt[i] << (CW * i);
      e.sat    = m_sat;
      return e;
   endfunction

   // Called at a falling edge; returns at the next falling edge with model and DUT in step.
   task automatic drive(input logic [NL-1:0] arr, input bit cr, input bit adv);
      car_arrive     = arr;
      car_cross      = cr;
      manual_advance = adv;
      model_step(arr, cr, adv, !rst_n);
      exp_q.push_back(snapshot());
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive('0, 1'b0, 1'b0);
   endtask

   task automatic wait_phase(input int ph, input int budget, input string tag);
      int n = 0;
      while (m_phase != ph && n < budget) begin
         drive('0, 1'b0, 1'b0);
         n++;
      end
      if (m_phase != ph) timeout(tag);
   endtask

   task automatic wait_tick(input int t, input int budget, input string tag);
      int n = 0;
      while (m_elapsed / TD < t && n < budget) begin
         drive('0, 1'b0, 1'b0);
         n++;
      end
      if (m_elapsed / TD < t) timeout(tag);
   endtask

   task automatic drain(input string tag);
      int  n = 0;
      bit  busy = 1'b1;
      while (busy && n < 600) begin
         busy = (m_phase != 0);
         for (int i = 0; i < NL; i++) if (m_cnt[i] > 0) busy = 1'b1;
         if (busy) begin
            drive('0, 1'b1, 1'b0);
            n++;
         end
      end
      if (busy) timeout(tag);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " phase"}, int'(phase), 0);
      check({tag, " light"}, int'(light), 0);
      check({tag, " counts"}, int'(car_count), 0);
      check({tag, " active_lane"}, int'(active_lane), 0);
      check({tag, " sat"}, int'(sat), 0);
   endtask

   // Asynchronous assertion must clear outputs before any clock edge.
   task automatic do_reset(input string tag);
      rst_n          = 1'b0;
      car_arrive     = '0;
      car_cross      = 1'b0;
      manual_advance = 1'b0;
      #1;
      check_reset_outputs(tag);
      @(negedge clk);
      idle(2);
      rst_n = 1'b1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("phase", int'(phase), e.phase);
            check("active_lane", int'(active_lane), e.lane);
            check("light", int'(light), e.light);
            check("car_count", int'(car_count), e.counts);
            check("sat", int'(sat), e.sat);
         end
      end
   end

   initial begin : stimulus
      int order[3];
      int sats;
      int n;
      order = '{1, 3, 0};

      #2;
      do_reset("power-on reset");

      // Idle crossroad never leaves ALL_RED.
      idle(200);
      check("idle phase", int'(phase), 0);
      check("idle light", int'(light), 0);

      // Three cars on lane 2, cleared after the minimum green time.
      for (int i = 0; i < 3; i++) drive(4'b0100, 1'b0, 1'b0);
      wait_phase(1, 20, "lane2 green");
      check("lane2 selected", int'(active_lane), 2);
      check("lane2 green light", int'(light[5:4]), 1);
      wait_tick(2, 40, "lane2 tick2");
      for (int i = 0; i < 3; i++) drive('0, 1'b1, 1'b0);
      wait_phase(2, 10, "lane2 yellow");
      wait_phase(0, 20, "lane2 all-red");

      // Lane 1 never empties: green runs to its maximum and lane 1 is picked again.
      for (int i = 0; i < 7; i++) drive(4'b0010, 1'b0, 1'b0);
      wait_phase(1, 20, "lane1 green");
      check("lane1 selected", int'(active_lane), 1);
      wait_phase(2, 40, "lane1 max green");
      wait_phase(0, 20, "lane1 all-red");
      wait_phase(1, 20, "lane1 reselect");
      check("lane1 reselected", int'(active_lane), 1);
      drain("drain after lane1");

      // Round robin from pointer 0 serves 1, 3, 0 and skips empty lane 2.
      drive(4'b0001, 1'b0, 1'b0);
      wait_phase(1, 20, "lane0 green");
      check("lane0 selected", int'(active_lane), 0);
      drain("drain after lane0");
      drive(4'b1011, 1'b0, 1'b0);
      for (int j = 0; j < 3; j++) begin
         wait_phase(1, 40, "rr green");
         check("rr service order", int'(active_lane), order[j]);
         n = 0;
         while (m_phase == 1 && n < 50) begin
            drive('0, 1'b1, 1'b0);
            n++;
         end
      end
      drain("drain after rr");

      // Saturation on lane 3, then arrive+cross in the same cycle.
      sats = 0;
      for (int i = 0; i < 9; i++) begin
         drive(4'b1000, 1'b0, 1'b0);
         sats += int'(sat[3]);
      end
      idle(1);
      sats += int'(sat[3]);
      check("lane3 sat pulses", sats, 2);
      check("lane3 saturated count", int'(car_count[9 +: 3]), MAXC);
      wait_phase(1, 20, "lane3 green");
      drive(4'b1000, 1'b1, 1'b0);
      check("arrive+cross at max", int'(car_count[9 +: 3]), MAXC);
      check("arrive+cross at max no sat", int'(sat[3]), 0);
      drive('0, 1'b1, 1'b0);
      drive(4'b1000, 1'b1, 1'b0);
      check("arrive+cross mid count", int'(car_count[9 +: 3]), MAXC - 1);
      drain("drain after lane3");

      // manual_advance before GREEN_MIN is dropped; at GREEN_MIN it ends green.
      for (int i = 0; i < 3; i++) drive(4'b0001, 1'b0, 1'b0);
      wait_phase(1, 20, "advance green");
      wait_tick(1, 20, "advance tick1");
      drive('0, 1'b0, 1'b1);
      check("early advance ignored", int'(phase), 1);
      wait_tick(2, 20, "advance tick2");
      drive('0, 1'b0, 1'b1);
      check("advance at min green", int'(phase), 2);
      wait_phase(0, 20, "advance all-red");

      // Reset in the middle of a green phase.
      for (int i = 0; i < 2; i++) drive(4'b0010, 1'b0, 1'b0);
      wait_phase(1, 20, "pre-reset green");
      idle(3);
      do_reset("mid-green reset");

      // Randomised traffic: light load, then heavy load that saturates counters.
      for (int c = 0; c < 1500; c++) begin
         logic [NL-1:0] a;
         for (int i = 0; i < NL; i++) a[i] = ($urandom_range(0, 7) == 0);
         drive(a, $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
      end
      do_reset("random reset");
      for (int c = 0; c < 1500; c++) begin
         logic [NL-1:0] a;
         for (int i = 0; i < NL; i++) a[i] = ($urandom_range(0, 2) == 0);
         drive(a, $urandom_range(0, 5) == 0, $urandom_range(0, 31) == 0);
      end

      idle(3);
      @(posedge clk);
      #2;
      check("scoreboard drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
